mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Load/store bus controller sitting directly downstream of the execute unit's memory port. It converts the execute unit's level-held memory select into a single req/gnt/rvalid transaction on the data bus, and returns read data with a one-cycle acknowledge. It also bounds every access with a timeout so a dead slave cannot hang the core's load/store hold.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles allowed in REQ+WAIT before forced completion (1..255).
- `clk` input 1: core clock, all state on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `mem_sel_i` input 1: access request level from execute unit.
- `mem_wen_i` input 1: 1 = store, 0 = load.
- `mem_addr_i` input 32: byte address.
- `mem_wdata_i` input 32: store data, already lane-aligned.
- `mem_wmask_i` input 4: store byte enables.
- `mem_rdata_o` output 32: load data word (unshifted) back to execute unit.
- `mem_ack_o` output 1: one-cycle completion pulse.
- `mem_err_o` output 1: one-cycle pulse coincident with `mem_ack_o` when the access timed out.
- `busy_o` output 1: high in any state other than IDLE.
- `bus_req_o` output 1: bus request.
- `bus_we_o` output 1: bus write.
- `bus_addr_o` output 32: word-aligned bus address.
- `bus_wdata_o` output 32: bus write data.
- `bus_be_o` output 4: bus byte enables.
- `bus_gnt_i` input 1: request accepted.
- `bus_rvalid_i` input 1: response valid (reads and writes).
- `bus_rdata_i` input 32: read data, valid with `bus_rvalid_i`.

## Operation
- States: IDLE, REQ, WAIT, DONE, RELEASE.
- IDLE: when `mem_sel_i`=1 at a clock edge, latch `mem_wen_i`, `{mem_addr_i[31:2],2'b00}`, `mem_wdata_i`, and the byte enables (`mem_wmask_i` for stores, 4'b1111 for loads); clear the timeout counter; go to REQ.
- REQ: `bus_req_o`=1 with the latched attributes held constant. `bus_gnt_i`=1 -> WAIT. `bus_rvalid_i` is ignored in REQ.
- WAIT: `bus_req_o`=0. `bus_rvalid_i`=1 -> capture `bus_rdata_i` into `mem_rdata_o` (stores capture nothing) -> DONE.
- DONE: `mem_ack_o`=1 for exactly one cycle -> RELEASE.
- RELEASE: wait for `mem_sel_i`=0, then go to IDLE. The execute unit keeps select high for two cycles after ack; this state prevents a duplicate access.
- Timeout: 8-bit counter increments on each cycle spent in REQ or WAIT. When the counter equals `TIMEOUT_CYCLES` with no completing handshake in that cycle, go to DONE with `mem_err_o`=1 and `mem_rdata_o`=32'h0.
  - Handshake and timeout in the same cycle: the handshake wins.
  - Timeout in REQ drops `bus_req_o` without a grant.
- `mem_sel_i` falling mid-transaction does not abort it. The transaction completes and the ack still pulses, followed by RELEASE (exits immediately).
- Input changes after latching have no effect until the next IDLE acceptance.
- `mem_rdata_o` holds its value from capture until the next load capture or timeout. Stores leave it unchanged.
- `bus_addr_o`, `bus_wdata_o`, `bus_be_o`, `bus_we_o` are registered and hold their last latched values outside REQ.

## Timing
- Reset (asynchronous, immediate): state IDLE; `bus_req_o`, `bus_we_o`, `mem_ack_o`, `mem_err_o`, `busy_o` = 0; `bus_addr_o`, `bus_wdata_o`, `mem_rdata_o` = 0; `bus_be_o` = 0; counter = 0. Reset during REQ drops `bus_req_o` without waiting for the clock.
- Zero-wait slave, load example:
  - `mem_sel_i` sampled high at edge E0.
  - `bus_req_o` is high in cycle E0–E1; `bus_gnt_i` is high in the same cycle.
  - WAIT in E1–E2; `bus_rvalid_i` is high.
  - `mem_ack_o` is high in E2–E3.
  - Minimum latency from select sampled to ack is 3 cycles.
- Each grant wait cycle and each response wait cycle adds one cycle.
- All outputs are registered; there is no combinational path from bus inputs to `mem_*` outputs.
- Back-to-back: the next access cannot be accepted earlier than the edge after `mem_sel_i` is seen low in RELEASE.

## Test plan
- Load, zero-wait: addr 0x1000_0006, `bus_rdata_i`=0xA5B6C7D8 -> `bus_addr_o`=0x1000_0004, `bus_be_o`=4'b1111, `bus_we_o`=0; ack 3 cycles after select; `mem_rdata_o`=0xA5B6C7D8; `mem_err_o`=0.
- Store with stalls: addr 0x20, wdata 0x0000_AB00, mask 4'b0010; gnt delayed 4 cycles, rvalid delayed 2 -> `bus_req_o` held 5 cycles with stable attributes; ack 9 cycles after select; `mem_rdata_o` unchanged.
- Select held 2 cycles past ack (execute-unit behaviour) -> exactly one bus request; return to IDLE; a second select then launches a new access.
- Timeout: `TIMEOUT_CYCLES`=8, `bus_gnt_i` never asserted -> `bus_req_o` drops after 8 cycles; `mem_ack_o` and `mem_err_o` pulse together; `mem_rdata_o`=0.
- Simultaneous events: `bus_rvalid_i` arrives on the timeout cycle -> normal completion, `mem_err_o`=0, data captured.
- Reset mid-WAIT: `rst_n` low for 1 cycle -> all outputs return to reset values at once; no ack; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_ctrl.sv
// Load/store bus controller: turns a level-held execute-unit select into one
// req/gnt/rvalid bus transaction, with a per-access timeout and a one-cycle ack.
module mem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_sel_i,
    input  logic        mem_wen_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wmask_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        busy_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    // The counter holds the number of REQ/WAIT cycles already completed, so the
    // cycle in which it reads TIMEOUT_CYCLES-1 is the last one allowed.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        timeout;
    logic        capture;
    logic        expire;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr_i[1:0];

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        expire     = 1'b0;
        timeout    = (cnt >= TO_LAST);
        unique case (state)
            S_IDLE: begin
                if (mem_sel_i) state_next = S_REQ;
            end
            S_REQ: begin
                if (bus_gnt_i) begin
                    state_next = S_WAIT;
                end else if (timeout) begin
                    state_next = S_DONE;
                    expire     = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus_rvalid_i) begin
                    state_next = S_DONE;
                    capture    = 1'b1;
                end else if (timeout) begin
                    state_next = S_DONE;
                    expire     = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!mem_sel_i) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are plain flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= 8'd0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_wdata_o <= 32'd0;
            bus_be_o    <= 4'd0;
            mem_ack_o   <= 1'b0;
            mem_err_o   <= 1'b0;
            busy_o      <= 1'b0;
            mem_rdata_o <= 32'd0;
        end else begin
            state     <= state_next;
            bus_req_o <= (state_next == S_REQ);
            mem_ack_o <= (state_next == S_DONE);
            mem_err_o <= expire;
            busy_o    <= (state_next != S_IDLE);

            if (state == S_IDLE && mem_sel_i) begin
                bus_we_o    <= mem_wen_i;
                bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                bus_wdata_o <= mem_wdata_i;
                bus_be_o    <= mem_wen_i ? mem_wmask_i : 4'b1111;
                cnt         <= 8'd0;
            end else if ((state == S_REQ || state == S_WAIT) && cnt != 8'hff) begin
                cnt <= cnt + 8'd1;
            end

            if (capture && !bus_we_o) begin
                mem_rdata_o <= bus_rdata_i;
            end else if (expire) begin
                mem_rdata_o <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, randomized accesses
// against a cycle-count model, and a mid-access reset sequence.
module tb_mem_ctrl;

    localparam int T = 8;

    logic        clk;
    logic        rst_n;
    logic        mem_sel;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        busy;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_sel_i    (mem_sel),
        .mem_wen_i    (mem_wen),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_wmask_i  (mem_wmask),
        .mem_rdata_o  (mem_rdata),
        .mem_ack_o    (mem_ack),
        .mem_err_o    (mem_err),
        .busy_o       (busy),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_be_o     (bus_be),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          g;
        int          r;
        logic [31:0] rd;
        logic        no_gnt;
        logic        drop;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        int          exp_lat;
        int          exp_req;
        logic        exp_err;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd  = 32'd0;

    // slave configuration, set per access
    int          g_cfg = 0;
    int          r_cfg = 0;
    logic [31:0] rd_cfg = 32'd0;
    logic        no_gnt = 1'b0;
    int          req_cnt = 0;
    int          wait_cnt = 0;
    logic        in_wait = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reactive slave: grant on the (g+1)th request cycle, respond on the (r+1)th wait cycle.
    always @(negedge clk) begin
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        if (!rst_n) begin
            req_cnt  = 0;
            wait_cnt = 0;
            in_wait  = 1'b0;
        end else if (in_wait) begin
            if (mem_ack) begin
                in_wait = 1'b0;
            end else begin
                wait_cnt++;
                if (wait_cnt == r_cfg + 1) begin
                    bus_rvalid = 1'b1;
                    bus_rdata  = rd_cfg;
                    in_wait    = 1'b0;
                end
            end
        end else if (bus_req) begin
            req_cnt++;
            if (req_cnt == g_cfg + 1 && !no_gnt) begin
                bus_gnt  = 1'b1;
                in_wait  = 1'b1;
                wait_cnt = 0;
                req_cnt  = 0;
            end
        end else begin
            req_cnt = 0;
        end
    end

    // Reference model: an access needs (g+1) request cycles plus (r+1) response
    // cycles; if that exceeds T it is cut off after T cycles with an error.
    function automatic vec_t model(input logic wen, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] mask,
                                   input int g, input int r, input logic [31:0] rd,
                                   input logic drop);
        vec_t v;
        int   total;
        v.wen      = wen;
        v.addr     = addr;
        v.wdata    = wdata;
        v.mask     = mask;
        v.g        = g;
        v.r        = r;
        v.rd       = rd;
        v.no_gnt   = 1'b0;
        v.drop     = drop;
        v.exp_addr = addr & 32'hFFFF_FFFC;
        v.exp_be   = wen ? mask : 4'hF;
        total      = (g + 1) + (r + 1);
        v.exp_err  = (total > T);
        v.exp_lat  = (total > T ? T : total) + 1;
        v.exp_req  = g + 1;
        return v;
    endfunction

    task automatic run_access(input vec_t v);
        int          n;
        int          reqs;
        int          bad;
        int          extra;
        logic        got_ack;
        logic        err_at;
        logic [31:0] exp_rd;
        g_cfg  = v.g;
        r_cfg  = v.r;
        rd_cfg = v.rd;
        no_gnt = v.no_gnt;
        if (v.exp_err)  exp_rd = 32'd0;
        else if (!v.wen) exp_rd = v.rd;
        else            exp_rd = last_rd;
        last_rd = exp_rd;
        exp_q.push_back(exp_rd);

        @(negedge clk);
        mem_sel   = 1'b1;
        mem_wen   = v.wen;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wmask = v.mask;
        n = 0; reqs = 0; bad = 0; extra = 0; got_ack = 1'b0; err_at = 1'b0;
        while (!got_ack && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                mem_wen   = ~v.wen;
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_wmask = 4'($urandom_range(0, 15));
                if (v.drop) mem_sel = 1'b0;
            end
            if (bus_req) begin
                reqs++;
                if (bus_addr !== v.exp_addr || bus_be !== v.exp_be ||
                    bus_we !== v.wen || bus_wdata !== v.wdata) bad++;
            end
            if (mem_ack) begin
                got_ack = 1'b1;
                err_at  = mem_err;
            end
        end
        check("ack_seen", 32'(got_ack), 32'd1);
        check("latency", n, v.exp_lat);
        check("err", 32'(err_at), 32'(v.exp_err));
        check("req_cycles", reqs, v.exp_req);
        check("attr_stable", bad, 0);
        check("rdata", mem_rdata, exp_q.pop_front());

        @(negedge clk);
        check("ack_pulse", 32'(mem_ack), 32'd0);
        check("busy_release", 32'(busy), 32'd1);
        if (bus_req) extra++;
        if (!v.drop) begin
            @(negedge clk);
            if (bus_req) extra++;
            mem_sel = 1'b0;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus_req) extra++;
        end while (busy && n < 10);
        check("idle", 32'(busy), 32'd0);
        check("no_dup_req", extra, 0);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        rst_n = 1'b0; mem_sel = 1'b0; mem_wen = 1'b0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_wmask = 4'd0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        bus_rdata = 32'd0;

        // directed table: wen addr wdata mask g r rd no_gnt drop | addr be lat req err
        vecs[0] = '{1'b0, 32'h1000_0006, 32'h0, 4'h0, 0, 0, 32'hA5B6_C7D8, 1'b0, 1'b0,
                    32'h1000_0004, 4'hF, 3, 1, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 4, 2, 32'hDEAD_BEEF, 1'b0, 1'b0,
                    32'h0000_0020, 4'b0010, 9, 5, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0044, 32'h5555_AAAA, 4'h3, 0, 0, 32'h1357_9BDF, 1'b0, 1'b0,
                    32'h0000_0044, 4'hF, 3, 1, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_1237, 32'h0, 4'h0, 0, 0, 32'hFFFF_FFFF, 1'b1, 1'b0,
                    32'h0000_1234, 4'hF, 9, 8, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 6, 32'hCAFE_F00D, 1'b0, 1'b0,
                    32'h0000_0100, 4'hF, 9, 1, 1'b0};
        vecs[5] = '{1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 7, 32'h7777_7777, 1'b0, 1'b0,
                    32'h0000_0200, 4'hF, 9, 2, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_3003, 32'h1234_5678, 4'b1100, 1, 1, 32'h0BAD_0BAD, 1'b0, 1'b1,
                    32'h0000_3000, 4'b1100, 5, 2, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_4008, 32'h0, 4'h0, 2, 0, 32'h1111_2222, 1'b0, 1'b1,
                    32'h0000_4008, 4'hF, 5, 3, 1'b0};

        #12;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack_err", {30'd0, mem_ack, mem_err}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_be_we", {27'd0, bus_be, bus_we}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_access(vecs[i]);

        for (int i = 0; i < 24; i++) begin
            v = model(1'($urandom_range(0, 1)), $urandom, $urandom,
                      4'($urandom_range(0, 15)), $urandom_range(0, T - 2),
                      $urandom_range(0, 7), $urandom, 1'($urandom_range(0, 1)));
            run_access(v);
        end

        // reset while waiting for the response
        g_cfg = 0; r_cfg = 5; rd_cfg = 32'h9999_0000; no_gnt = 1'b0;
        @(negedge clk);
        mem_sel = 1'b1; mem_wen = 1'b0; mem_addr = 32'h0000_0500;
        mem_wdata = 32'h0F0F_0F0F; mem_wmask = 4'h0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_req", 32'(bus_req), 32'd0);
        check("arst_addr", bus_addr, 32'd0);
        check("arst_wdata", bus_wdata, 32'd0);
        check("arst_rdata", mem_rdata, 32'd0);
        check("arst_misc", {26'd0, bus_be, bus_we, mem_ack, mem_err}, 32'd0);
        mem_sel = 1'b0;
        @(negedge clk);
        check("arst_no_ack", 32'(mem_ack), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        last_rd = 32'd0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        run_access(model(1'b0, 32'h0000_0600, 32'h0, 4'h0, 1, 1, 32'h2468_ACE0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
